// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: host-loaded program memory, PC sequencer,
// stall bubbles and a trailing NOP drain before signalling done.
module instr_fetch_stage #(
  parameter int          DEPTH        = 64,
  parameter int          AW           = 6,
  parameter logic [31:0] NOP          = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stall,
  output logic [31:0]   instr_out,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int CW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] DRAIN_L = CW'(DRAIN_CYCLES);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          idle_like;
  logic          last;

  logic [31:0] mem_q [DEPTH];

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign last      = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  // Program memory is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (load_en && idle_like) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    instr_d = NOP;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
          pc_d    = '0;
          state_d = (prog_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          instr_d = mem_q[pc_q];
          valid_d = 1'b1;
          if (last) begin
            pc_d    = '0;
            cnt_d   = DRAIN_L;
            state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage: expected output stream is built
// from the program words, the stall pattern and the drain length.
module tb_instr_fetch_stage;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DRAIN = 3;
  localparam logic [31:0] NOPW = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [31:0]   instr_out;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] model_mem [DEPTH];

  instr_fetch_stage #(
    .DEPTH(DEPTH),
    .AW(AW),
    .NOP(NOPW),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .prog_len(prog_len),
    .start(start),
    .stall(stall),
    .instr_out(instr_out),
    .instr_valid(instr_valid),
    .pc(pc),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    step();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Runs a program; mask forces stalls on chosen fetch cycles.
  task automatic run(input int len, input int pct,
                     input logic [63:0] mask, output int cyc);
    int  n;
    int  idx;
    bit  st;
    n = (len > DEPTH) ? DEPTH : len;
    prog_len = (AW+1)'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    chk("start_valid", 32'(instr_valid), 0);
    chk("start_pc", 32'(pc), 0);
    if (n == 0) begin
      chk("len0_done", 32'(done), 1);
      chk("len0_busy", 32'(busy), 0);
      return;
    end
    chk("start_busy", 32'(busy), 1);
    chk("start_done", 32'(done), 0);
    idx = 0;
    while (idx < n && cyc < 4000) begin
      st = ($urandom_range(0, 99) < pct) || (cyc < 64 && mask[cyc]);
      stall     = st;
      start     = ($urandom_range(0, 7) == 0);
      load_en   = ($urandom_range(0, 5) == 0);
      load_addr = AW'($urandom);
      load_data = $urandom;
      step();
      cyc++;
      stall   = 1'b0;
      start   = 1'b0;
      load_en = 1'b0;
      if (st) begin
        chk("stall_valid", 32'(instr_valid), 0);
        chk("stall_instr", instr_out, NOPW);
      end else begin
        chk("run_valid", 32'(instr_valid), 1);
        chk("run_instr", instr_out, model_mem[idx]);
        idx++;
      end
      chk("run_pc", 32'(pc), (idx == n) ? 0 : idx);
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
    end
    chk("run_timeout", idx, n);
    for (int d = 0; d < DRAIN; d++) begin
      stall = 1'($urandom);
      start = 1'($urandom);
      step();
      stall = 1'b0;
      start = 1'b0;
      chk("drain_valid", 32'(instr_valid), 0);
      chk("drain_instr", instr_out, NOPW);
      chk("drain_busy", 32'(busy), (d < DRAIN - 1) ? 1 : 0);
      chk("drain_done", 32'(done), (d == DRAIN - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int c;
    int l;
    #1 rst = 1'b1;
    #1;
    chk("rst_instr", instr_out, NOPW);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    wr(0, 32'h11);
    wr(1, 32'h22);
    wr(2, 32'h33);
    run(3, 0, 64'h0, c);
    chk("plain_cycles", c, 3);

    run(3, 0, 64'h6, c);
    chk("stall_cycles", c, 5);

    run(0, 0, 64'h0, c);
    step();
    chk("len0_hold_done", 32'(done), 1);
    chk("len0_hold_valid", 32'(instr_valid), 0);

    for (int i = 0; i < DEPTH; i++) wr(i, 32'(i));
    run(DEPTH, 0, 64'h0, c);
    chk("full_cycles", c, DEPTH);
    run(70, 30, 64'h0, c);

    prog_len = 7'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_pc", 32'(pc), 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_instr", instr_out, NOPW);
    chk("mid_rst_valid", 32'(instr_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pc", 32'(pc), 0);
    #1 rst = 1'b0;
    run(3, 0, 64'h0, c);

    wr(0, 32'hABCD);
    run(1, 0, 64'h0, c);

    for (int r = 0; r < 6; r++) begin
      l = $urandom_range(1, 24);
      for (int i = 0; i < l; i++) wr(i, $urandom);
      run(l, 25, 64'h0, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the 3-stage datapath and drives its 32-bit instruction input every cycle.
- Holds a small program memory that a host loads while the stage is idle.
- Sequences a PC through the loaded program and presents one instruction per cycle, or a NOP bubble when stalled.
- After the last instruction, issues enough trailing NOPs for the downstream write-back to complete, then signals done.

Parameters:
DEPTH, 64, number of 32-bit program memory words
AW, 6, address/PC width; must satisfy 2**AW == DEPTH
NOP, 32'h0000_0000, bubble encoding driven when no valid instruction is issued
DRAIN_CYCLES, 3, NOP cycles issued after the last instruction (matches downstream pipeline depth)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
load_en  input  1  program-memory write strobe
load_addr  input  AW  program-memory write address
load_data  input  32  program-memory write data
prog_len  input  AW+1  number of instructions to run, sampled on accepted start
start  input  1  begin execution (level sampled each edge)
stall  input  1  hold PC and issue NOP this cycle
instr_out  output  32  registered instruction to downstream datapath
instr_valid  output  1  instr_out holds a real instruction (not a bubble)
pc  output  AW  address of next instruction to fetch
busy  output  1  state is RUN or DRAIN
done  output  1  state is DONE

Behaviour:
- Reset (async, immediate): state=IDLE, instr_out=NOP, instr_valid=0, pc=0, busy=0, done=0, len and drain counter cleared. Program memory is not reset; contents survive rst.
- Memory write: synchronous; mem[load_addr]<=load_data when load_en and state in {IDLE, DONE}. load_en in RUN/DRAIN is ignored, with no side effects.
- All outputs are registered; instr_out/instr_valid change only on clk edges or async reset.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE, start=1:
  - len<=min(prog_len, DEPTH); pc<=0; instr_out<=NOP; instr_valid<=0.
  - If prog_len==0 -> DONE (done=1 next cycle). Else -> RUN, done<=0.
- IDLE/DONE, start=0: hold. stall has no effect.
- RUN, stall=0: instr_out<=mem[pc]; instr_valid<=1.
  - If pc==len-1: pc<=0, drain counter<=DRAIN_CYCLES, -> DRAIN.
  - Else pc<=pc+1.
- RUN, stall=1: instr_out<=NOP, instr_valid<=0, pc held, state held. Stall may last any number of cycles.
- Latency: start sampled at edge E0; mem[0] appears on instr_out after E1 (absent stall). Without stalls, mem[k] appears after E(k+1).
- DRAIN:
  - Each edge: instr_out<=NOP, instr_valid<=0, counter decrements.
  - When counter reaches 0 (DRAIN_CYCLES edges total), -> DONE.
  - stall is ignored.
  - If DRAIN_CYCLES==0, go RUN -> DONE directly.
- start in RUN/DRAIN: ignored. start is not queued.
- DONE: done=1 until the next accepted start (done clears on that edge) or rst.
- busy=1 exactly when state is RUN or DRAIN; done and busy are never both 1.
- pc wrap: with len==DEPTH the last fetch is at DEPTH-1, then pc is forced to 0; pc never overflows.
- prog_len > DEPTH: clamped to DEPTH.
- Reset mid-RUN/DRAIN: returns to IDLE immediately. The in-flight instr_out is replaced by NOP. A new start re-executes from pc 0.

Test Plan:
- Load mem[0..2]=32'h11,32'h22,32'h33; prog_len=3; pulse start -> instr_out sequence 11,22,33 with instr_valid=1, then 3 NOP cycles with valid=0, then done=1, busy=0.
- Same program; stall high for 2 cycles while pc=1 -> output 11, NOP, NOP, 22, 33; pc holds 1 during stall; total RUN cycles = 5.
- prog_len=0, start -> no valid instruction issued; done=1 one cycle after start; busy never asserts.
- prog_len=DEPTH(64), mem[i]=i -> 64 valid words 0..63 in order, pc returns to 0; load_en pulse at addr 5 with data FFFF_FFFF mid-run is ignored (word 5 still reads 5 on a rerun).
- Assert rst asynchronously mid-RUN at pc=2 -> instr_out=NOP, valid=0, busy=0 before the next edge; restart reproduces the program from mem[0], proving memory retained.
- In DONE, load mem[0]=32'hABCD, start with prog_len=1 -> instr_out=ABCD for one cycle, done cleared during run, reasserted after drain.
